wash_sequencer: RTL and testbench
=================================

Name: wash_sequencer

Overview:
- Runs a washing-machine program from start to finish.
- Takes the 26-bit packed program time word produced by the program-setting model and steps through its eight timed fields in order. Fields with a value of zero are skipped.
- Counts down each field on an external 1-tick enable and drives the valve and motor actuators for the active phase.
- Reports per-phase and total remaining time to the display path and flags completion to the top-level state machine.

Parameters:
- BUZZ_TICKS, 3, number of ticks the buzzer stays on after completion (used only with SEQ_BUZZER_EN).

Ports:
- cp  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- tick  in  1  one-cycle time-base enable (one program time unit).
- start  in  1  launch the program; sampled only in IDLE or DONE.
- pause  in  1  level; while high, the countdown is frozen.
- abort  in  1  one-cycle pulse; return to IDLE.
- program  in  26  packed field times, latched on start.
- phase  out  3  active field index, 0..7.
- field_left  out  4  ticks remaining in the active field.
- total_left  out  7  ticks remaining in the whole program.
- busy  out  1  state is RUN or PAUSE.
- paused  out  1  state is PAUSE.
- done  out  1  state is DONE.
- finish_pulse  out  1  one cycle high on entry to DONE.
- water_valve, drain_valve, motor_slow, motor_fast  out  1 each  actuator enables.
- buzzer  out  1  end-of-program alert.

Behaviour:
- Field map, MSB first:
  - 0 fill1 [25:23]
  - 1 wash [22:19]
  - 2 drain1 [18:16]
  - 3 spin1 [15:13]
  - 4 fill2 [12:10]
  - 5 rinse [9:6]
  - 6 drain2 [5:3]
  - 7 spin2 [2:0]
- 3-bit fields are zero-extended to 4 bits.
- Actuators by field:
  - fill: water_valve.
  - wash or rinse: motor_slow.
  - drain: drain_valve.
  - spin: drain_valve and motor_fast.
  - All actuators are 0 outside RUN.
- Reset: state IDLE; every output 0; the latched program register is 0.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE or DONE with start:
  - Latch program.
  - total_left is loaded with the sum of all eight fields; maximum 72.
  - phase and field_left are loaded from the first nonzero field.
  - Next state is RUN, one-cycle latency.
  - If all fields are zero, go to DONE directly and pulse finish_pulse.
- RUN with tick:
  - total_left and field_left each decrement by 1.
  - If field_left is 1, the next nonzero field after phase is loaded in the same edge.
  - If no nonzero field remains, go to DONE with total_left 0 and finish_pulse high for one cycle.
- RUN with pause high: go to PAUSE; a tick in the same cycle is ignored.
- PAUSE: counters hold and ticks are ignored. When pause goes low, return to RUN on the next edge.
- DONE:
  - done stays high; phase, field_left and total_left are 0.
  - A new start relaunches the program.
- Priority within a cycle: abort, then pause, then tick.
  - abort from any state forces IDLE and clears all counters and outputs.
  - start is ignored in RUN or PAUSE.
  - pause is ignored in IDLE and DONE.
- program changes after start have no effect until the next start.
- Asynchronous rst mid-program: outputs go to 0 immediately; the next start is required to run.

Optional Feature:
- SEQ_BUZZER_EN defined:
  - On entry to DONE, buzzer goes high and stays high for BUZZ_TICKS ticks, then low.
  - start or abort clears buzzer immediately.
- SEQ_BUZZER_EN undefined: the buzzer port is tied to 0 and no buzzer counter is synthesized.

Decomposition:
- Package wash_seq_pkg holds:
  - state encoding
  - field index constants FLD_FILL1..FLD_SPIN2
  - field MSB/LSB offset constants
  - a field-kind enumeration (fill, agitate, drain, spin)
- Sub-module wash_next_field is natural. It takes the latched program and a current index, and returns a found flag, the next nonzero index and its 4-bit value. It is purely combinational and is used both at start (search from -1) and at field end.

Test Plan:
- Full program 26'b011_1010_100_101_011_1000_100_101 then start:
  - Expect phase 0, field_left 3, total_left 42, water_valve 1.
  - After 3 ticks: phase 1, field_left 10, motor_slow 1.
  - After 42 ticks: done, with finish_pulse for exactly one cycle.
- Dry-only program 26'b000_0000_000_000_000_0000_100_101:
  - Start gives phase 6, field_left 4, total_left 9, drain_valve 1.
  - After 4 ticks: phase 7 with motor_fast 1.
  - After 9 ticks: DONE.
- All-zero program plus start: DONE on the next edge with finish_pulse 1 and no actuator ever high.
- Pause during full-program wash, with 5 ticks already applied (total_left 37):
  - Hold pause for 10 ticks: total_left stays 37 and actuators are 0.
  - Release pause: the countdown resumes from 37.
- Custom program with water field 7, 26'b111_1010_100_101_111_1000_100_101:
  - total_left is 50.
  - abort after 20 ticks gives IDLE with all outputs 0.
  - start is ignored while RUN is asserted.
- With SEQ_BUZZER_EN and BUZZ_TICKS=3, after a program completes:
  - buzzer is high for exactly 3 ticks after DONE.
  - Reapplying start clears the buzzer in the same cycle.

Source files
------------

// File: rtl/wash_seq_pkg.sv
// wash_seq_pkg: shared definitions for the washing-machine sequencer.
//   - state_t       : sequencer state encoding (IDLE, RUN, PAUSE, DONE)
//   - field_kind_t  : what an individual program field does (fill, agitate, drain, spin)
//   - FLD_*         : field index constants, 0 = first field executed
//   - *_MSB/*_LSB   : bit positions of each field inside the packed program word
//   - field_value   : extract one field, zero-extended to 4 bits
//   - field_kind    : map a field index to its kind
//   - program_total : sum of all eight fields (at most 72)
package wash_seq_pkg;

  localparam int PROG_W = 26;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    KIND_FILL    = 2'd0,
    KIND_AGITATE = 2'd1,
    KIND_DRAIN   = 2'd2,
    KIND_SPIN    = 2'd3
  } field_kind_t;

  localparam logic [2:0] FLD_FILL1  = 3'd0;
  localparam logic [2:0] FLD_WASH   = 3'd1;
  localparam logic [2:0] FLD_DRAIN1 = 3'd2;
  localparam logic [2:0] FLD_SPIN1  = 3'd3;
  localparam logic [2:0] FLD_FILL2  = 3'd4;
  localparam logic [2:0] FLD_RINSE  = 3'd5;
  localparam logic [2:0] FLD_DRAIN2 = 3'd6;
  localparam logic [2:0] FLD_SPIN2  = 3'd7;

  localparam int FILL1_MSB  = 25, FILL1_LSB  = 23;
  localparam int WASH_MSB   = 22, WASH_LSB   = 19;
  localparam int DRAIN1_MSB = 18, DRAIN1_LSB = 16;
  localparam int SPIN1_MSB  = 15, SPIN1_LSB  = 13;
  localparam int FILL2_MSB  = 12, FILL2_LSB  = 10;
  localparam int RINSE_MSB  = 9,  RINSE_LSB  = 6;
  localparam int DRAIN2_MSB = 5,  DRAIN2_LSB = 3;
  localparam int SPIN2_MSB  = 2,  SPIN2_LSB  = 0;

  // Wash and rinse are the only 4-bit fields; the others get a zero MSB.
  function automatic logic [3:0] field_value(input logic [PROG_W-1:0] prog,
                                             input logic [2:0] idx);
    logic [3:0] v;
    v = '0;
    case (idx)
      FLD_FILL1:  v = {1'b0, prog[FILL1_MSB:FILL1_LSB]};
      FLD_WASH:   v = prog[WASH_MSB:WASH_LSB];
      FLD_DRAIN1: v = {1'b0, prog[DRAIN1_MSB:DRAIN1_LSB]};
      FLD_SPIN1:  v = {1'b0, prog[SPIN1_MSB:SPIN1_LSB]};
      FLD_FILL2:  v = {1'b0, prog[FILL2_MSB:FILL2_LSB]};
      FLD_RINSE:  v = prog[RINSE_MSB:RINSE_LSB];
      FLD_DRAIN2: v = {1'b0, prog[DRAIN2_MSB:DRAIN2_LSB]};
      default:    v = {1'b0, prog[SPIN2_MSB:SPIN2_LSB]};
    endcase
    return v;
  endfunction

  function automatic field_kind_t field_kind(input logic [2:0] idx);
    field_kind_t k;
    case (idx)
      FLD_FILL1, FLD_FILL2:   k = KIND_FILL;
      FLD_WASH, FLD_RINSE:    k = KIND_AGITATE;
      FLD_DRAIN1, FLD_DRAIN2: k = KIND_DRAIN;
      default:                k = KIND_SPIN;
    endcase
    return k;
  endfunction

  // 6 x 7 + 2 x 15 = 72 fits in 7 bits.
  function automatic logic [6:0] program_total(input logic [PROG_W-1:0] prog);
    logic [6:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s = s + {3'b000, field_value(prog, 3'(i))};
    end
    return s;
  endfunction

endpackage

// File: rtl/wash_next_field.sv
// wash_next_field: combinational search for the next nonzero program field.
// Ports:
//   prog       in  26  packed program word to search
//   from_start in  1   1 = search from the very first field (index "-1")
//   cur        in  3   current field index; only fields after it qualify
//   found      out 1   a qualifying nonzero field exists
//   idx        out 3   index of the first qualifying field
//   value      out 4   its zero-extended time
module wash_next_field
  import wash_seq_pkg::*;
(
  input  logic [PROG_W-1:0] prog,
  input  logic              from_start,
  input  logic [2:0]        cur,
  output logic              found,
  output logic [2:0]        idx,
  output logic [3:0]        value
);

  // Scanning downward lets the lowest qualifying index overwrite the others.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    value = '0;
    for (int i = 7; i >= 0; i--) begin
      if ((from_start || (3'(i) > cur)) && (field_value(prog, 3'(i)) != 4'd0)) begin
        found = 1'b1;
        idx   = 3'(i);
        value = field_value(prog, 3'(i));
      end
    end
  end

endmodule

// File: rtl/wash_sequencer.sv
// wash_sequencer: runs a washing-machine program through its eight timed fields.
// Optional feature macro: SEQ_BUZZER_EN (adds the BUZZ_TICKS parameter and a
// post-completion buzzer; without it the buzzer output is tied low).
// Ports:
//   cp           in  1   system clock, rising edge
//   rst          in  1   asynchronous active-high reset
//   tick         in  1   one-cycle time-base enable
//   start        in  1   launch program (honoured in IDLE/DONE only)
//   pause        in  1   level; freezes the countdown while in RUN/PAUSE
//   abort        in  1   pulse; forces IDLE and clears counters
//   prog         in  26  packed field times, latched on start
//                        (called prog because "program" is a reserved word)
//   phase        out 3   active field index
//   field_left   out 4   ticks remaining in the active field
//   total_left   out 7   ticks remaining in the whole program
//   busy/paused/done     state flags
//   finish_pulse out 1   one cycle high on entry to DONE
//   water_valve, drain_valve, motor_slow, motor_fast  actuator enables
//   buzzer       out 1   end-of-program alert
module wash_sequencer
  import wash_seq_pkg::*;
`ifdef SEQ_BUZZER_EN
#(
  parameter int BUZZ_TICKS = 3
)
`endif
(
  input  logic              cp,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  input  logic [PROG_W-1:0] prog,
  output logic [2:0]        phase,
  output logic [3:0]        field_left,
  output logic [6:0]        total_left,
  output logic              busy,
  output logic              paused,
  output logic              done,
  output logic              finish_pulse,
  output logic              water_valve,
  output logic              drain_valve,
  output logic              motor_slow,
  output logic              motor_fast,
  output logic              buzzer
);

  state_t            state, next_state;
  logic [PROG_W-1:0] prog_q, prog_nxt;
  logic [2:0]        phase_nxt;
  logic [3:0]        field_nxt;
  logic [6:0]        total_nxt;
  logic              finish_nxt;

  logic              start_found, next_found;
  logic [2:0]        start_idx, next_idx;
  logic [3:0]        start_val, next_val;

  // The launch search looks at the live input word because the latch happens
  // on the same edge; the field-end search uses the latched copy.
  wash_next_field u_start_search (
    .prog       (prog),
    .from_start (1'b1),
    .cur        (3'd0),
    .found      (start_found),
    .idx        (start_idx),
    .value      (start_val)
  );

  wash_next_field u_field_search (
    .prog       (prog_q),
    .from_start (1'b0),
    .cur        (phase),
    .found      (next_found),
    .idx        (next_idx),
    .value      (next_val)
  );

  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      prog_q       <= '0;
      phase        <= '0;
      field_left   <= '0;
      total_left   <= '0;
      finish_pulse <= 1'b0;
    end else begin
      state        <= next_state;
      prog_q       <= prog_nxt;
      phase        <= phase_nxt;
      field_left   <= field_nxt;
      total_left   <= total_nxt;
      finish_pulse <= finish_nxt;
    end
  end

  // Abort outranks everything; pause outranks tick inside RUN.
  always_comb begin
    next_state = state;
    prog_nxt   = prog_q;
    phase_nxt  = phase;
    field_nxt  = field_left;
    total_nxt  = total_left;
    finish_nxt = 1'b0;
    if (abort) begin
      next_state = ST_IDLE;
      phase_nxt  = '0;
      field_nxt  = '0;
      total_nxt  = '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            prog_nxt = prog;
            if (start_found) begin
              next_state = ST_RUN;
              phase_nxt  = start_idx;
              field_nxt  = start_val;
              total_nxt  = program_total(prog);
            end else begin
              next_state = ST_DONE;
              phase_nxt  = '0;
              field_nxt  = '0;
              total_nxt  = '0;
              finish_nxt = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (pause) begin
            next_state = ST_PAUSE;
          end else if (tick) begin
            total_nxt = total_left - 7'd1;
            if (field_left == 4'd1) begin
              if (next_found) begin
                phase_nxt = next_idx;
                field_nxt = next_val;
              end else begin
                next_state = ST_DONE;
                phase_nxt  = '0;
                field_nxt  = '0;
                total_nxt  = '0;
                finish_nxt = 1'b1;
              end
            end else begin
              field_nxt = field_left - 4'd1;
            end
          end
        end
        ST_PAUSE: begin
          if (!pause) next_state = ST_RUN;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  assign busy   = (state == ST_RUN) || (state == ST_PAUSE);
  assign paused = (state == ST_PAUSE);
  assign done   = (state == ST_DONE);

  always_comb begin
    water_valve = 1'b0;
    drain_valve = 1'b0;
    motor_slow  = 1'b0;
    motor_fast  = 1'b0;
    if (state == ST_RUN) begin
      case (field_kind(phase))
        KIND_FILL:    water_valve = 1'b1;
        KIND_AGITATE: motor_slow  = 1'b1;
        KIND_DRAIN:   drain_valve = 1'b1;
        default: begin
          drain_valve = 1'b1;
          motor_fast  = 1'b1;
        end
      endcase
    end
  end

`ifdef SEQ_BUZZER_EN
  localparam int BUZZ_W = $clog2(BUZZ_TICKS + 1);

  logic [BUZZ_W-1:0] buzz_cnt, buzz_nxt;

  // Loading on DONE entry wins over the start clear so an all-zero relaunch
  // still sounds; start/abort also mask the output in the same cycle.
  always_comb begin
    buzz_nxt = buzz_cnt;
    if (finish_nxt) begin
      buzz_nxt = BUZZ_W'(BUZZ_TICKS);
    end else if (start || abort) begin
      buzz_nxt = '0;
    end else if (tick && (buzz_cnt != '0)) begin
      buzz_nxt = buzz_cnt - BUZZ_W'(1);
    end
  end

  always_ff @(posedge cp or posedge rst) begin
    if (rst) buzz_cnt <= '0;
    else     buzz_cnt <= buzz_nxt;
  end

  assign buzzer = (buzz_cnt != '0) && !start && !abort;
`else
  assign buzzer = 1'b0;
`endif

endmodule

// File: tb/tb_wash_sequencer.sv
// tb_wash_sequencer: directed self-checking bench for wash_sequencer.
// Inputs change 1 time unit after a rising edge and outputs are sampled there,
// well away from the next active edge.
module tb_wash_sequencer;

  localparam logic [25:0] PROG_FULL   = 26'b011_1010_100_101_011_1000_100_101;
  localparam logic [25:0] PROG_DRY    = 26'b000_0000_000_000_000_0000_100_101;
  localparam logic [25:0] PROG_CUSTOM = 26'b111_1010_100_101_111_1000_100_101;
`ifdef SEQ_BUZZER_EN
  localparam logic BUZZ_ON = 1'b1;
`else
  localparam logic BUZZ_ON = 1'b0;
`endif

  logic        cp = 1'b0;
  logic        rst, tick, start, pause, abort;
  logic [25:0] prog;
  logic [2:0]  phase;
  logic [3:0]  field_left;
  logic [6:0]  total_left;
  logic        busy, paused, done, finish_pulse;
  logic        water_valve, drain_valve, motor_slow, motor_fast, buzzer;
  logic [3:0]  act;

  int numCompared   = 0;
  int numMismatched = 0;

  always #5 cp = ~cp;

  assign act = {water_valve, drain_valve, motor_slow, motor_fast};

  wash_sequencer dut (
    .cp           (cp),
    .rst          (rst),
    .tick         (tick),
    .start        (start),
    .pause        (pause),
    .abort        (abort),
    .prog         (prog),
    .phase        (phase),
    .field_left   (field_left),
    .total_left   (total_left),
    .busy         (busy),
    .paused       (paused),
    .done         (done),
    .finish_pulse (finish_pulse),
    .water_valve  (water_valve),
    .drain_valve  (drain_valve),
    .motor_slow   (motor_slow),
    .motor_fast   (motor_fast),
    .buzzer       (buzzer)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Holds tick/start/abort for the given number of edges, then drops them.
  task automatic applyStimulus(input logic t, input logic s, input logic a,
                               input int cycles);
    tick  = t;
    start = s;
    abort = a;
    repeat (cycles) begin
      @(posedge cp);
      #1;
    end
    tick  = 1'b0;
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0; prog = '0;
    #12;
    checkOutput("reset_outs", {phase, field_left, total_left, busy, paused, done,
                               finish_pulse, act, buzzer}, 32'd0);
    rst = 1'b0;
    @(posedge cp);
    #1;

    // pause has no effect in IDLE
    pause = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    checkOutput("idle_pause_ignored", {busy, paused, done}, 3'b000);
    pause = 1'b0;

    // full program
    prog = PROG_FULL;
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("full_start_pos", {phase, field_left, total_left}, {3'd0, 4'd3, 7'd42});
    checkOutput("full_start_act", {busy, act}, 5'b1_1000);
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    checkOutput("full_wash_pos", {phase, field_left, total_left}, {3'd1, 4'd10, 7'd39});
    checkOutput("full_wash_act", act, 4'b0010);
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    checkOutput("full_5ticks", {field_left, total_left}, {4'd8, 7'd37});

    // pause for ten ticks mid-wash
    pause = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 10);
    checkOutput("pause_hold", {paused, busy, field_left, total_left}, {1'b1, 1'b1, 4'd8, 7'd37});
    checkOutput("pause_act", act, 4'b0000);
    pause = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("pause_release", {paused, total_left, act}, {1'b0, 7'd37, 4'b0010});
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("resume_tick", {field_left, total_left}, {4'd7, 7'd36});
    applyStimulus(1'b1, 1'b0, 1'b0, 35);
    checkOutput("full_last_tick", {done, phase, field_left, total_left, act},
                {1'b0, 3'd7, 4'd1, 7'd1, 4'b0101});
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("full_done", {done, finish_pulse, busy, phase, field_left, total_left, act},
                {1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 7'd0, 4'b0000});
    checkOutput("buzz_entry", buzzer, BUZZ_ON);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("finish_one_cycle", {done, finish_pulse}, 2'b10);
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    checkOutput("buzz_two_ticks", buzzer, BUZZ_ON);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("buzz_three_ticks", buzzer, 1'b0);

    // dry-only program relaunched from DONE
    prog = PROG_DRY;
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("dry_start", {done, phase, field_left, total_left, act},
                {1'b0, 3'd6, 4'd4, 7'd9, 4'b0100});
    applyStimulus(1'b1, 1'b0, 1'b0, 4);
    checkOutput("dry_spin", {phase, field_left, total_left, act}, {3'd7, 4'd5, 7'd5, 4'b0101});
    applyStimulus(1'b1, 1'b0, 1'b0, 4);
    checkOutput("dry_before_end", {done, total_left}, {1'b0, 7'd1});
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("dry_done", {done, finish_pulse, total_left}, {1'b1, 1'b1, 7'd0});

    // all-zero program goes straight to DONE
    prog = '0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("zero_done", {done, finish_pulse, busy, total_left, act},
                {1'b1, 1'b1, 1'b0, 7'd0, 4'b0000});
    checkOutput("zero_buzz", buzzer, BUZZ_ON);
    start = 1'b1;
    #1;
    checkOutput("buzz_start_clear", buzzer, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("zero_relaunch", {done, finish_pulse}, 2'b11);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("zero_after", {done, finish_pulse, act}, {1'b1, 1'b0, 4'b0000});

    // custom program: ignored start, latched word, abort
    prog = PROG_CUSTOM;
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("custom_start", {phase, field_left, total_left}, {3'd0, 4'd7, 7'd50});
    applyStimulus(1'b1, 1'b0, 1'b0, 20);
    checkOutput("custom_20", {phase, field_left, total_left, act}, {3'd2, 4'd1, 7'd30, 4'b0100});
    prog = '0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("start_ignored", {busy, done, phase, field_left, total_left},
                {1'b1, 1'b0, 3'd2, 4'd1, 7'd30});
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("latched_word", {phase, field_left, total_left, act}, {3'd3, 4'd5, 7'd29, 4'b0101});
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    checkOutput("abort_idle", {phase, field_left, total_left, busy, paused, done,
                               finish_pulse, act, buzzer}, 32'd0);

    // asynchronous reset mid-program
    prog = PROG_FULL;
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    checkOutput("prereset_total", total_left, 7'd40);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", {phase, field_left, total_left, busy, done, act}, 32'd0);
    rst = 1'b0;
    @(posedge cp);
    #1;
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    checkOutput("reset_stays_idle", {busy, done, total_left}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("restart_after_reset", {busy, phase, total_left}, {1'b1, 3'd0, 7'd42});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
